// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter
// Brief    : Round-robin arbiter driving the 2-bit select of a 4:1 data mux.
//            Grant is held until a valid/ready transfer, then priority
//            rotates past the served source. Optional macro ARB_LAST_EN adds
//            req_last so a source keeps the grant until its last item.
// Revision : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter #(
    parameter int RESET_PTR = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
`ifdef ARB_LAST_EN
    input  logic [3:0] req_last,
`endif
    input  logic       out_ready,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       out_valid
);

    localparam logic [0:0] c_IDLE      = 1'b0;
    localparam logic [0:0] c_GRANT     = 1'b1;
    localparam logic [1:0] c_RESET_PTR = RESET_PTR[1:0];

    logic [0:0] r_state;
    logic [1:0] r_ptr;
    logic [3:0] r_grant;
    logic [1:0] r_sel;
    logic       r_valid;

    logic [0:0] w_state_nxt;
    logic [1:0] w_ptr_nxt;
    logic [3:0] w_grant_nxt;
    logic [1:0] w_sel_nxt;
    logic       w_valid_nxt;

    logic       w_xfer;
    logic       w_last;
    logic [1:0] w_rot_ptr;
    logic [1:0] w_hunt_ptr;
    logic [2:0] w_hit;

    // Returns {found, index} of the first requester at or after ptr (mod 4).
    function automatic logic [2:0] f_search(input logic [1:0] ptr,
                                            input logic [3:0] req_v);
        logic [1:0] idx;
        f_search = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req_v[idx]) begin
                f_search = {1'b1, idx};
            end
        end
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_ptr   <= c_RESET_PTR;
            r_grant <= 4'b0000;
            r_sel   <= c_RESET_PTR;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
            r_sel   <= w_sel_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_valid_nxt = r_valid;

        w_xfer    = r_valid & out_ready;
`ifdef ARB_LAST_EN
        w_last    = req_last[r_sel];
`else
        w_last    = 1'b1;
`endif
        w_rot_ptr = r_sel + 2'd1;
        // After a completed transfer the search already starts past the
        // served source, so back-to-back grants need no idle bubble.
        w_hunt_ptr = (r_state == c_GRANT) ? w_rot_ptr : r_ptr;
        w_hit      = f_search(w_hunt_ptr, req);

        case (r_state)
            c_IDLE: begin
                if (w_hit[2]) begin
                    w_state_nxt = c_GRANT;
                    w_grant_nxt = 4'b0001 << w_hit[1:0];
                    w_sel_nxt   = w_hit[1:0];
                    w_valid_nxt = 1'b1;
                end
            end
            c_GRANT: begin
                if (w_xfer && w_last) begin
                    w_ptr_nxt = w_rot_ptr;
                    if (w_hit[2]) begin
                        w_grant_nxt = 4'b0001 << w_hit[1:0];
                        w_sel_nxt   = w_hit[1:0];
                    end else begin
                        w_state_nxt = c_IDLE;
                        w_grant_nxt = 4'b0000;
                        w_valid_nxt = 1'b0;
                    end
                end else if (!req[r_sel]) begin
                    // Abandoned (or a non-last item with the request gone):
                    // release and demote the source that walked away.
                    w_ptr_nxt   = w_rot_ptr;
                    w_state_nxt = c_IDLE;
                    w_grant_nxt = 4'b0000;
                    w_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_grant_nxt = 4'b0000;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign grant     = r_grant;
    assign sel       = r_sel;
    assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_rr_arbiter
// Brief    : Directed and random checks of mux4_rr_arbiter against a
//            behavioural owner/pointer model. Honors macro ARB_LAST_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux4_rr_arbiter;

    localparam int RESET_PTR = 0;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] req_last;
    logic       out_ready;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       out_valid;

    int checks   = 0;
    int failures = 0;

    // Model: owner is the granted source (-1 when idle).
    int m_owner;
    int m_ptr;
    int m_sel;

    mux4_rr_arbiter #(.RESET_PTR(RESET_PTR)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
`ifdef ARB_LAST_EN
        .req_last  (req_last),
`endif
        .out_ready (out_ready),
        .grant     (grant),
        .sel       (sel),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input int p, input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = RESET_PTR;
        m_sel   = RESET_PTR;
    endtask

    task automatic model_step(input logic [3:0] r, input logic rdy,
                              input logic [3:0] lst);
        bit last;
`ifdef ARB_LAST_EN
        last = (m_owner >= 0) ? lst[m_owner] : 1'b1;
`else
        last = 1'b1;
`endif
        if (m_owner < 0) begin
            m_owner = pick(m_ptr, r);
        end else if (rdy && last) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = pick(m_ptr, r);
        end else if (!r[m_owner]) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
        end
        if (m_owner >= 0) m_sel = m_owner;
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] eg;
        eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        check({tag, ".grant"},  32'(grant),     32'(eg));
        check({tag, ".sel"},    32'(sel),       32'(m_sel));
        check({tag, ".valid"},  32'(out_valid), 32'(m_owner >= 0));
        check({tag, ".onehot"}, 32'($onehot0(grant)), 32'd1);
        check({tag, ".vor"},    32'(out_valid), 32'(|grant));
    endtask

    task automatic step(input string tag, input logic [3:0] r, input logic rdy,
                        input logic [3:0] lst = 4'hF);
        req       = r;
        out_ready = rdy;
        req_last  = lst;
        model_step(r, rdy, lst);
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        rst       = 1'b1;
        req       = 4'b1111;
        req_last  = 4'hF;
        out_ready = 1'b1;
        model_reset();
        #2;
        check_outputs("reset");

        // Full contention: one transfer per cycle, sel 0,1,2,3,0.
        @(negedge clk);
        rst = 1'b0;
        step("rr0", 4'b1111, 1'b1); check("rr0.const", 32'(sel), 32'd0);
        step("rr1", 4'b1111, 1'b1); check("rr1.const", 32'(sel), 32'd1);
        step("rr2", 4'b1111, 1'b1); check("rr2.const", 32'(sel), 32'd2);
        step("rr3", 4'b1111, 1'b1); check("rr3.const", 32'(sel), 32'd3);
        step("rr4", 4'b1111, 1'b1); check("rr4.const", 32'(sel), 32'd0);
        step("drain1", 4'b0000, 1'b1);

        // Sole requester stalled for five cycles, then transferred.
        step("stall_g", 4'b0100, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step("stall", 4'b0100, 1'b0);
            check("stall.const", 32'(grant), 32'h4);
        end
        step("stall_x", 4'b0100, 1'b1);
        step("stall_idle", 4'b0000, 1'b1);
        check("stall_idle.const", 32'(out_valid), 32'd0);

        // Wrap from source 3 to source 0 and back.
        step("wrap_g", 4'b1000, 1'b0);
        step("wrap0", 4'b1001, 1'b1); check("wrap0.const", 32'(sel), 32'd0);
        step("wrap3", 4'b1001, 1'b1); check("wrap3.const", 32'(sel), 32'd3);
        step("drain2", 4'b0000, 1'b1);

        // Abandon on source 1, then priority starts at 2.
        step("ab_g", 4'b0010, 1'b0);
        step("ab_drop", 4'b0000, 1'b0);
        check("ab_drop.const", 32'(out_valid), 32'd0);
        step("ab_next", 4'b0011, 1'b0);
        check("ab_next.const", 32'(sel), 32'd0);
        step("drain3", 4'b0000, 1'b1);

        // Asynchronous reset in the middle of a grant.
        step("ar_g", 4'b0010, 1'b0);
        check("ar_g.const", 32'(grant), 32'h2);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step("drain4", 4'b0000, 1'b1);

`ifdef ARB_LAST_EN
        // Packet lock: source 2 keeps the grant until its last item.
        step("pk_g", 4'b0100, 1'b0);
        step("pk1", 4'b1111, 1'b1, 4'b0000); check("pk1.const", 32'(sel), 32'd2);
        step("pk2", 4'b1111, 1'b1, 4'b0000); check("pk2.const", 32'(sel), 32'd2);
        step("pk3", 4'b1111, 1'b1, 4'b0100); check("pk3.const", 32'(sel), 32'd3);
        step("drain5", 4'b0000, 1'b1);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step("rand", 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
